test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 143 ++++++++++++++
 tb/tb_test_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// test_sequencer: walks up to 16 test stages in order, starting each enabled
// stage, waiting for its finish (or a cycle timeout), and recording per-stage
// failures plus an overall pass/timeout summary.
module test_sequencer #(
    parameter int N_STAGES = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go_i,
    input  logic [N_STAGES-1:0] enable_mask_i,
    input  logic [N_STAGES-1:0] finish_i,
    input  logic [N_STAGES-1:0] fail_i,
    output logic [N_STAGES-1:0] start_o,
    output logic [3:0]          cur_stage_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [N_STAGES-1:0] fail_mask_o,
    output logic                timeout_o
);

    localparam int unsigned NS     = unsigned'(N_STAGES);
    localparam int          TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned T_LAST = (TIMEOUT > 0) ? unsigned'(TIMEOUT - 1) : 0;
    localparam logic [3:0]  LAST_STAGE = 4'(N_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_stage;
    logic [TW-1:0]         r_timer;
    logic [N_STAGES-1:0]   r_fail_mask;
    logic                  r_timeout;

    logic                  w_en;
    logic                  w_fin;
    logic                  w_fail;
    logic                  w_last;
    logic                  w_tmo;
    logic                  w_stage_end;

    // Pick out the current stage's enable/finish/fail bits; other stages ignored
    always_comb begin
        w_en   = 1'b0;
        w_fin  = 1'b0;
        w_fail = 1'b0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (r_stage == 4'(i)) begin
                w_en   = enable_mask_i[i];
                w_fin  = finish_i[i];
                w_fail = fail_i[i];
            end
        end
        w_last      = (r_stage == LAST_STAGE);
        w_tmo       = (TIMEOUT > 0) && (r_timer == TW'(T_LAST));
        w_stage_end = w_fin || w_tmo;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (go_i) w_next_state = S_SCAN;
            end
            S_SCAN: begin
                if (w_en)        w_next_state = S_WAIT;
                else if (w_last) w_next_state = S_DONE;
            end
            S_WAIT: begin
                if (w_stage_end) w_next_state = w_last ? S_DONE : S_SCAN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Stage index, WAIT timer and sticky result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage     <= '0;
            r_timer     <= '0;
            r_fail_mask <= '0;
            r_timeout   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (go_i) begin
                        r_stage     <= '0;
                        r_fail_mask <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_en)         r_timer <= '0;
                    else if (!w_last) r_stage <= r_stage + 4'd1;
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_stage_end) begin
                        // finish takes priority over a coincident timeout
                        for (int unsigned i = 0; i < NS; i++) begin
                            if (r_stage == 4'(i)) r_fail_mask[i] <= w_fin ? w_fail : 1'b1;
                        end
                        if (!w_fin) r_timeout <= 1'b1;
                        if (!w_last) r_stage <= r_stage + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        start_o = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            start_o[i] = (r_state == S_WAIT) && (r_stage == 4'(i));
        end
        cur_stage_o = r_stage;
        busy_o      = (r_state == S_SCAN) || (r_state == S_WAIT);
        done_o      = (r_state == S_DONE);
        pass_o      = (r_state == S_DONE) && (r_fail_mask == '0);
        fail_mask_o = r_fail_mask;
        timeout_o   = r_timeout;
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer with 4 stages and an 8-cycle timeout.
module tb_test_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       go_i;
    logic [3:0] enable_mask_i;
    logic [3:0] finish_i;
    logic [3:0] fail_i;
    logic [3:0] start_o;
    logic [3:0] cur_stage_o;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
    logic [3:0] fail_mask_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] seen;

    test_sequencer #(.N_STAGES(4), .TIMEOUT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .go_i          (go_i),
        .enable_mask_i (enable_mask_i),
        .finish_i      (finish_i),
        .fail_i        (fail_i),
        .start_o       (start_o),
        .cur_stage_o   (cur_stage_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pass_o        (pass_o),
        .fail_mask_o   (fail_mask_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    // Accumulate every start bit ever observed
    always @(negedge clk) seen <= seen | start_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for start_o to show stage idx; any other start is an error
    task automatic wait_start(input int idx);
        logic [3:0] tgt;
        bit found;
        bit other;
        tgt   = 4'(1) << idx;
        found = 1'b0;
        other = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (start_o == tgt)       found = 1'b1;
            else if (start_o != 4'd0) other = 1'b1;
        end
        check("start_seen", 32'(found), 32'd1);
        check("no_stray_start", 32'(other), 32'd0);
        if (found) check("cur_stage", 32'(cur_stage_o), 32'(idx));
    endtask

    // Stage idx is in its first WAIT cycle; finish so start is high cyc cycles
    task automatic finish_after(input int idx, input int cyc, input bit f);
        logic [3:0] tgt;
        tgt = 4'(1) << idx;
        for (int k = 1; k < cyc; k++) begin
            tick();
            check("start_hold", 32'(start_o), 32'(tgt));
        end
        finish_i = tgt;
        fail_i   = f ? tgt : 4'd0;
        tick();
        check("start_drop", 32'(start_o), 32'd0);
        finish_i = 4'd0;
        fail_i   = 4'd0;
    endtask

    task automatic pulse_go();
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
    endtask

    initial begin
        int cnt;
        reset         = 1'b1;
        go_i          = 1'b0;
        enable_mask_i = 4'd0;
        finish_i      = 4'd0;
        fail_i        = 4'd0;
        seen          = 4'd0;
        tick();
        tick();
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_pass", 32'(pass_o), 32'd0);
        check("rst_fmask", 32'(fail_mask_o), 32'd0);
        check("rst_tmo", 32'(timeout_o), 32'd0);
        check("rst_stage", 32'(cur_stage_o), 32'd0);
        reset = 1'b0;
        tick();

        // All four stages, each finishes 3 cycles after start, no failures
        enable_mask_i = 4'b1111;
        seen = 4'd0;
        pulse_go();
        check("t1_scan_busy", 32'(busy_o), 32'd1);
        check("t1_scan_start", 32'(start_o), 32'd0);
        for (int s = 0; s < 4; s++) begin
            wait_start(s);
            finish_after(s, 3, 1'b0);
        end
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_pass", 32'(pass_o), 32'd1);
        check("t1_fmask", 32'(fail_mask_o), 32'd0);
        check("t1_busy", 32'(busy_o), 32'd0);
        check("t1_seen", 32'(seen), 32'b1111);
        tick(); tick(); tick();
        check("t1_hold_done", 32'(done_o), 32'd1);
        check("t1_hold_pass", 32'(pass_o), 32'd1);

        // Mask 1010, stage 3 reports failure
        enable_mask_i = 4'b1010;
        seen = 4'd0;
        pulse_go();
        wait_start(1);
        finish_after(1, 2, 1'b0);
        wait_start(3);
        finish_after(3, 1, 1'b1);
        check("t2_done", 32'(done_o), 32'd1);
        check("t2_fmask", 32'(fail_mask_o), 32'b1000);
        check("t2_pass", 32'(pass_o), 32'd0);
        check("t2_seen", 32'(seen), 32'b1010);
        tick(); tick();
        check("t2_hold_fmask", 32'(fail_mask_o), 32'b1000);

        // Stage 1 times out; go and stage-3 finish/fail poked while it runs
        enable_mask_i = 4'b1111;
        pulse_go();
        check("t3_fmask_clr", 32'(fail_mask_o), 32'd0);
        wait_start(0);
        finish_after(0, 1, 1'b0);
        wait_start(1);
        go_i     = 1'b1;
        finish_i = 4'b1000;
        fail_i   = 4'b1000;
        cnt = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 1) begin
                go_i     = 1'b0;
                finish_i = 4'd0;
                fail_i   = 4'd0;
            end
            if (start_o == 4'b0010) cnt++;
            else break;
        end
        check("t3_tmo_len", 32'(cnt), 32'd8);
        check("t3_tmo_flag", 32'(timeout_o), 32'd1);
        check("t3_fmask", 32'(fail_mask_o), 32'b0010);
        check("t3_stage", 32'(cur_stage_o), 32'd2);
        wait_start(2);
        finish_after(2, 1, 1'b0);
        wait_start(3);
        finish_after(3, 1, 1'b0);
        check("t3_done", 32'(done_o), 32'd1);
        check("t3_pass", 32'(pass_o), 32'd0);
        check("t3_end_fmask", 32'(fail_mask_o), 32'b0010);
        check("t3_end_tmo", 32'(timeout_o), 32'd1);

        // Finish on the final (8th) WAIT cycle beats the timeout
        enable_mask_i = 4'b0001;
        pulse_go();
        check("t4_tmo_clr", 32'(timeout_o), 32'd0);
        wait_start(0);
        finish_after(0, 8, 1'b1);
        check("t4_tmo", 32'(timeout_o), 32'd0);
        check("t4_fmask", 32'(fail_mask_o), 32'b0001);
        tick(); tick();
        check("t4_not_done", 32'(done_o), 32'd0);
        tick();
        check("t4_done", 32'(done_o), 32'd1);
        check("t4_pass", 32'(pass_o), 32'd0);

        // All stages disabled: N_STAGES SCAN cycles then DONE with pass
        enable_mask_i = 4'b0000;
        pulse_go();
        tick(); tick(); tick();
        check("t5_busy", 32'(busy_o), 32'd1);
        check("t5_stage", 32'(cur_stage_o), 32'd3);
        check("t5_not_done", 32'(done_o), 32'd0);
        tick();
        check("t5_done", 32'(done_o), 32'd1);
        check("t5_pass", 32'(pass_o), 32'd1);

        // Reset in the middle of stage 2 WAIT, then restart from stage 0
        enable_mask_i = 4'b1111;
        pulse_go();
        wait_start(0);
        finish_after(0, 1, 1'b0);
        wait_start(1);
        finish_after(1, 1, 1'b1);
        wait_start(2);
        tick();
        check("t6_pre_fmask", 32'(fail_mask_o), 32'b0010);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_start", 32'(start_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_fmask", 32'(fail_mask_o), 32'd0);
        check("t6_stage", 32'(cur_stage_o), 32'd0);
        tick();
        check("t6_idle", 32'(busy_o), 32'd0);
        pulse_go();
        for (int s = 0; s < 4; s++) begin
            wait_start(s);
            finish_after(s, 2, 1'b0);
        end
        check("t6_done", 32'(done_o), 32'd1);
        check("t6_pass", 32'(pass_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
